instr_word_encoder: RTL and testbench
=====================================

Name: instr_word_encoder

Overview:
- Inverse of the main opcode decoder: packs instruction fields (class, registers, funct, immediate) into 32-bit MIPS words for the four supported classes: R-type, lw, sw and beq.
- Buffers the encoded words in a small FIFO.
- Streams the words into instruction memory through a write port with backpressure, one word per beat, at sequential word addresses.
- Used by the bench/boot path to load programs that the decoder will later consume.

Parameters:
- DEPTH, 4, FIFO entries (power of two, >=2)
- AW, 10, instruction memory byte-address width
- BASE_ADDR, 0, address of first word after reset (multiple of 4)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept bundle
- in_class  input  2  00=R, 01=lw, 10=sw, 11=beq
- in_rs  input  5  source register
- in_rt  input  5  target register
- in_rd  input  5  destination (R only)
- in_funct  input  6  function code (R only)
- in_imm  input  16  immediate/offset (lw/sw/beq)
- flush  input  1  discard all buffered words
- addr_load  input  1  load write address
- addr_value  input  AW  new write address (low 2 bits ignored)
- imem_we  output  1  write request valid
- imem_ready  input  1  memory accepts write this cycle
- imem_addr  output  AW  byte address of current word
- imem_wdata  output  32  encoded word
- words_written  output  16  count of completed writes, saturating at 16'hFFFF
- empty  output  1  FIFO empty

Behaviour:
- Encoding (combinational, on input fields):
  - R: {6'd0, rs, rt, rd, 5'd0, funct}
  - lw: {6'd35, rs, rt, imm}
  - sw: {6'd43, rs, rt, imm}
  - beq: {6'd4, rs, rt, imm}
  - Unused fields are ignored.
- Input handshake:
  - Push occurs when in_valid & in_ready.
  - in_ready = !full & !flush. There is no pass-through when full: in_ready stays 0 while full even if a pop happens in the same cycle.
- Output handshake:
  - imem_we = !empty.
  - imem_wdata is the FIFO head; imem_addr is the current address register.
  - A write completes when imem_we & imem_ready. On completion: the head is popped, the address increments by 4, and words_written increments.
  - imem_wdata and imem_addr stay stable while imem_we=1 and imem_ready=0.
- Latency: a word pushed in cycle N is presented on imem_wdata in cycle N+1 at the earliest (registered FIFO). Sustained throughput is 1 word/cycle when imem_ready is held high.
- Push and pop in the same cycle (not full, not empty): occupancy is unchanged and order is preserved.
- Address:
  - Wraps modulo 2^AW. Bits [1:0] are always 0.
  - addr_load has priority over increment. If a write completes in the same cycle as addr_load, that write uses the old address and the next address = {addr_value[AW-1:2], 2'b00}.
- flush:
  - Synchronous. Next cycle, occupancy = 0 and empty = 1.
  - Any push in the flush cycle is dropped (in_ready=0).
  - A write completing in the flush cycle still counts and still increments the address.
  - flush does not change the address unless addr_load is also asserted.
- Reset (async, rst_n=0): FIFO empty, in_ready=1 after deassertion, imem_we=0, imem_wdata=0, imem_addr=BASE_ADDR, words_written=0, empty=1. Reset mid-stream discards all buffered words.
- FIFO boundary conditions:
  - full when occupancy = DEPTH.
  - Read/write pointers wrap modulo DEPTH, with an extra bit to distinguish full from empty.

Test Plan:
- Single R encode: after reset, push class=00, rs=1, rt=2, rd=3, funct=6'h20, imem_ready=1 -> next cycle imem_we=1, imem_addr=0, imem_wdata=32'h00221820. One cycle later imem_we=0 and words_written=1.
- All classes: push lw (rs=0, rt=8, imm=4), sw (rs=0, rt=8, imm=8), beq (rs=8, rt=9, imm=16'hFFFF) back-to-back -> words 8C080004, AC080008, 1109FFFF at addresses 0, 4, 8 on consecutive cycles.
- Backpressure/full: imem_ready=0 while pushing 6 bundles -> in_ready drops after DEPTH=4 accepted; imem_wdata/imem_addr hold. Release imem_ready -> 4 words drain in order, then in_ready=1.
- Address load and wrap: addr_load with 10'h3FC -> next write at 3FC, following write at 000. Load coincident with a completing write -> that write keeps its old address, the next write uses the loaded value.
- Flush: buffer 3 words with imem_ready=0, pulse flush together with in_valid -> empty=1 next cycle, imem_we=0, pushed word dropped, address unchanged.
- Async reset mid-stream: assert rst_n=0 between clock edges with 2 words buffered -> outputs immediately cleared, imem_addr=BASE_ADDR, words_written=0.

Source files
------------

// File: rtl/instr_word_encoder_if.sv
// Bundle of the encoder's two handshakes: the field-bundle input side and the
// instruction-memory write side. The encoder takes the slave view and the
// program loader (or bench) takes the master view.
//
// Both sides follow the same valid/ready rule. A transfer happens on a rising
// clock edge where valid and ready are both 1. The producer must not lower
// valid or change its payload because ready is low. The consumer may raise or
// lower ready at any time, and ready may depend combinationally on the
// current-cycle inputs.
interface instr_word_encoder_if #(
    parameter int AW = 10
);
    // Field bundle input side
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_class;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [4:0]    in_rd;
    logic [5:0]    in_funct;
    logic [15:0]   in_imm;

    // Control
    logic          flush;
    logic          addr_load;
    logic [AW-1:0] addr_value;

    // Instruction memory write side
    logic          imem_we;
    logic          imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;

    // Status
    logic [15:0]   words_written;
    logic          empty;

    modport master (
        output in_valid, in_class, in_rs, in_rt, in_rd, in_funct, in_imm,
        output flush, addr_load, addr_value, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, words_written, empty
    );

    modport slave (
        input  in_valid, in_class, in_rs, in_rt, in_rd, in_funct, in_imm,
        input  flush, addr_load, addr_value, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, words_written, empty
    );
endinterface

// File: rtl/instr_word_encoder.sv
// Packs R-type / lw / sw / beq fields into 32-bit MIPS words, buffers them in
// a small FIFO and streams them into instruction memory at sequential word
// addresses. Used by the boot path to load programs for the opcode decoder.
module instr_word_encoder #(
    parameter int DEPTH     = 4,
    parameter int AW        = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_word_encoder_if.slave bus
);
    localparam int PW = $clog2(DEPTH);

    localparam logic [AW-1:0] BASE_RAW  = AW'(BASE_ADDR);
    localparam logic [AW-1:0] BASE_WORD = {BASE_RAW[AW-1:2], 2'b00};
    localparam logic [AW-1:0] ADDR_STEP = AW'(4);
    localparam logic [PW:0]   PTR_ONE   = (PW+1)'(1);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    logic [31:0]   mem [DEPTH];
    logic [PW:0]   wrPtr;
    logic [PW:0]   rdPtr;
    logic [AW-1:0] addrReg;
    logic [15:0]   wordCount;
    logic [31:0]   encWord;
    logic          fifoFull;
    logic          fifoEmpty;
    logic          doPush;
    logic          doPop;

    // Pack the incoming fields; fields not used by a class are dropped.
    always_comb begin
        encWord = '0;
        unique case (bus.in_class)
            2'b00: encWord = {OP_RTYPE, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, bus.in_funct};
            2'b01: encWord = {OP_LW,    bus.in_rs, bus.in_rt, bus.in_imm};
            2'b10: encWord = {OP_SW,    bus.in_rs, bus.in_rt, bus.in_imm};
            2'b11: encWord = {OP_BEQ,   bus.in_rs, bus.in_rt, bus.in_imm};
            default: encWord = '0;
        endcase
    end

    // The extra pointer bit tells a full FIFO from an empty one.
    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);

    // No pass-through when full: a pop in the same cycle does not open the input.
    assign bus.in_ready = !fifoFull && !bus.flush;
    assign doPush       = bus.in_valid && bus.in_ready;
    assign bus.imem_we  = !fifoEmpty;
    assign doPop        = bus.imem_we && bus.imem_ready;

    assign bus.imem_wdata    = mem[rdPtr[PW-1:0]];
    assign bus.imem_addr     = addrReg;
    assign bus.words_written = wordCount;
    assign bus.empty         = fifoEmpty;

    // FIFO pointers; flush collapses the read pointer onto the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else if (bus.flush) begin
            rdPtr <= wrPtr;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_ONE;
            if (doPop)  rdPtr <= rdPtr + PTR_ONE;
        end
    end

    // FIFO storage; cleared on reset so the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (doPush) begin
            mem[wrPtr[PW-1:0]] <= encWord;
        end
    end

    // Write address: a load wins over the post-write increment; wraps at 2^AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrReg <= BASE_WORD;
        end else if (bus.addr_load) begin
            addrReg <= {bus.addr_value[AW-1:2], 2'b00};
        end else if (doPop) begin
            addrReg <= addrReg + ADDR_STEP;
        end
    end

    // Completed-write counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wordCount <= '0;
        end else if (doPop && (wordCount != 16'hFFFF)) begin
            wordCount <= wordCount + 16'd1;
        end
    end
endmodule

// File: tb/tb_instr_word_encoder.sv
// Bench for instr_word_encoder: fixed encode vectors, directed multi-cycle
// sequences and a randomized run, all compared against a queue-based model.
module tb_instr_word_encoder;
    localparam int DEPTH = 4;
    localparam int AW    = 10;
    localparam int BASE  = 0;

    typedef struct {
        logic [1:0]  cls;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] expWord;
    } vec_t;

    logic clk;
    logic rst_n;

    instr_word_encoder_if #(.AW(AW)) bus ();

    instr_word_encoder #(
        .DEPTH(DEPTH),
        .AW(AW),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [31:0] expQ[$];
    int modAddr;
    int modCount;
    int passCnt;
    int totalCnt;
    vec_t vecs[7];

    // Instruction word from the field rules, by plain arithmetic.
    function automatic logic [31:0] refEncode(int cls, int rs, int rt, int rd, int fn, int imm);
        longint w;
        longint op;
        case (cls)
            0: op = 0;
            1: op = 35;
            2: op = 43;
            default: op = 4;
        endcase
        if (cls == 0) w = longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(rd) * 2048 + longint'(fn);
        else          w = op * 67108864 + longint'(rs) * 2097152 + longint'(rt) * 65536 + longint'(imm);
        return 32'(w);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        totalCnt++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        else passCnt++;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic checkOutputs();
        logic expReady;
        expReady = (expQ.size() < DEPTH) && !bus.flush;
        chk("in_ready", 32'(bus.in_ready), 32'(expReady));
        chk("imem_we", 32'(bus.imem_we), 32'(expQ.size() != 0));
        chk("empty", 32'(bus.empty), 32'(expQ.size() == 0));
        chk("imem_addr", 32'(bus.imem_addr), 32'(modAddr));
        chk("words_written", 32'(bus.words_written), 32'(modCount));
        if (expQ.size() != 0) chk("imem_wdata", bus.imem_wdata, expQ[0]);
    endtask

    // Advance the model by the rising edge that follows.
    task automatic modelUpdate();
        logic rdy;
        logic pop;
        logic push;
        logic [31:0] w;
        rdy  = (expQ.size() < DEPTH) && !bus.flush;
        pop  = (expQ.size() != 0) && bus.imem_ready;
        push = bus.in_valid && rdy;
        w = refEncode(int'(bus.in_class), int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                      int'(bus.in_funct), int'(bus.in_imm));
        if (pop) begin
            void'(expQ.pop_front());
            if (modCount < 65535) modCount++;
        end
        if (bus.addr_load) modAddr = (int'(bus.addr_value) / 4) * 4;
        else if (pop)      modAddr = (modAddr + 4) % (2 ** AW);
        if (bus.flush) expQ.delete();
        else if (push) expQ.push_back(w);
    endtask

    // One clock: inputs are already set at the falling edge.
    task automatic step();
        #1;
        checkOutputs();
        modelUpdate();
        @(negedge clk);
    endtask

    // Driver tasks
    task automatic idle();
        bus.in_valid   = 1'b0;
        bus.flush      = 1'b0;
        bus.addr_load  = 1'b0;
        bus.addr_value = '0;
    endtask

    task automatic setPush(input vec_t v);
        bus.in_valid = 1'b1;
        bus.in_class = v.cls;
        bus.in_rs    = v.rs;
        bus.in_rt    = v.rt;
        bus.in_rd    = v.rd;
        bus.in_funct = v.fn;
        bus.in_imm   = v.imm;
    endtask

    task automatic randomFields();
        bus.in_class = 2'($urandom_range(0, 3));
        bus.in_rs    = 5'($urandom_range(0, 31));
        bus.in_rt    = 5'($urandom_range(0, 31));
        bus.in_rd    = 5'($urandom_range(0, 31));
        bus.in_funct = 6'($urandom_range(0, 63));
        bus.in_imm   = 16'($urandom_range(0, 65535));
    endtask

    task automatic randomPush();
        randomFields();
        bus.in_valid = 1'b1;
    endtask

    initial begin
        int savedAddr;
        passCnt  = 0;
        totalCnt = 0;
        modAddr  = BASE;
        modCount = 0;

        vecs[0] = '{2'b00, 5'd1,  5'd2,  5'd3,  6'h20, 16'h0000, 32'h00221820};
        vecs[1] = '{2'b01, 5'd0,  5'd8,  5'd0,  6'h00, 16'h0004, 32'h8C080004};
        vecs[2] = '{2'b10, 5'd0,  5'd8,  5'd0,  6'h00, 16'h0008, 32'hAC080008};
        vecs[3] = '{2'b11, 5'd8,  5'd9,  5'd0,  6'h00, 16'hFFFF, 32'h1109FFFF};
        vecs[4] = '{2'b00, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h1234, 32'h03FFF83F};
        vecs[5] = '{2'b01, 5'd31, 5'd31, 5'd7,  6'h15, 16'hFFFF, 32'h8FFFFFFF};
        vecs[6] = '{2'b00, 5'd0,  5'd0,  5'd0,  6'h00, 16'hFFFF, 32'h00000000};

        rst_n = 1'b0;
        idle();
        randomFields();
        bus.imem_ready = 1'b0;
        #1;
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'(BASE));
        chk("rst_count", 32'(bus.words_written), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Encode vectors, pushed back-to-back with the memory always ready
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            setPush(vecs[i]);
            step();
            bus.in_valid = 1'b0;
            #1;
            chk($sformatf("tbl_word%0d", i), bus.imem_wdata, vecs[i].expWord);
            chk($sformatf("tbl_addr%0d", i), 32'(bus.imem_addr), 32'(i * 4));
            chk($sformatf("tbl_we%0d", i), 32'(bus.imem_we), 32'd1);
        end
        idle();
        step();
        chk("tbl_count", 32'(bus.words_written), 32'd7);
        chk("tbl_drained", 32'(bus.imem_we), 32'd0);

        // Backpressure: six offers with the memory stalled, then drain
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            randomPush();
            step();
        end
        idle();
        #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("drain_empty", 32'(bus.empty), 32'd1);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);

        // Address load and wrap
        bus.addr_load  = 1'b1;
        bus.addr_value = 10'h3FC;
        step();
        idle();
        chk("load_addr", 32'(bus.imem_addr), 32'h3FC);
        randomPush();
        step();
        randomPush();
        #1;
        chk("wrap_first", 32'(bus.imem_addr), 32'h3FC);
        step();
        idle();
        #1;
        chk("wrap_second", 32'(bus.imem_addr), 32'h000);
        step();

        // Load coinciding with a completing write
        bus.imem_ready = 1'b0;
        randomPush();
        step();
        randomPush();
        step();
        idle();
        bus.imem_ready = 1'b1;
        bus.addr_load  = 1'b1;
        bus.addr_value = 10'h103;
        #1;
        chk("coinc_old_addr", 32'(bus.imem_addr), 32'h004);
        step();
        idle();
        chk("coinc_new_addr", 32'(bus.imem_addr), 32'h100);
        step();

        // Flush with a push offered in the same cycle
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomPush();
            step();
        end
        savedAddr = modAddr;
        randomPush();
        bus.flush = 1'b1;
        step();
        idle();
        #1;
        chk("flush_empty", 32'(bus.empty), 32'd1);
        chk("flush_we", 32'(bus.imem_we), 32'd0);
        chk("flush_addr", 32'(bus.imem_addr), 32'(savedAddr));
        step();

        // Asynchronous reset between edges with two words buffered
        randomPush();
        step();
        randomPush();
        step();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", 32'(bus.imem_we), 32'd0);
        chk("arst_wdata", bus.imem_wdata, 32'd0);
        chk("arst_addr", 32'(bus.imem_addr), 32'(BASE));
        chk("arst_count", 32'(bus.words_written), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        expQ.delete();
        modAddr  = BASE;
        modCount = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            randomFields();
            bus.in_valid   = 1'($urandom_range(0, 1));
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            bus.flush      = ($urandom_range(0, 19) == 0);
            bus.addr_load  = ($urandom_range(0, 15) == 0);
            bus.addr_value = AW'($urandom_range(0, 2 ** AW - 1));
            step();
        end
        idle();
        bus.imem_ready = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) step();
        #1;
        checkOutputs();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
